// File: rtl/shift_sched_pkg.sv
// Shared definitions for the shift scheduler: state encoding, parameter
// limits and the round-robin winner selection.
package shift_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  localparam int unsigned WidthMin = 2;
  localparam int unsigned WidthMax = 32;
  localparam int unsigned DepthMin = 1;
  localparam int unsigned DepthMax = 16;

  // A lone requester wins outright; on a tie the source that was not served last wins.
  function automatic logic pick_winner(input logic [1:0] req, input logic last_owner);
    logic w;
    unique case (req)
      2'b01:   w = 1'b0;
      2'b10:   w = 1'b1;
      default: w = ~last_owner;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/shift_chain.sv
// DEPTH-stage (data, valid) flop pipeline with asynchronous active-low clear.
module shift_chain #(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_data,
  input  logic in_valid,
  output logic out_data,
  output logic out_valid
);

  logic [DEPTH-1:0] data_q;
  logic [DEPTH-1:0] valid_q;

  // Shift both lanes one stage per cycle; stage 0 takes the injected bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      data_q[0]  <= in_data;
      valid_q[0] <= in_valid;
      for (int i = 1; i < int'(DEPTH); i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  assign out_data  = data_q[DEPTH-1];
  assign out_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/shift_sched.sv
// Two-source round-robin scheduler feeding one serial shift chain.
// A granted word is shifted out MSB-first, then the chain is flushed before
// the next grant so done lines up with the last payload bit at the tail.
module shift_sched
  import shift_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       ack,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             owner,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CntWordLast  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CntFlushLast = CNT_W'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic             winner;
  logic             inj_data, inj_valid;

  assign winner = pick_winner(req, last_owner_q);

  // Next-state, grant and chain-injection logic.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    ack          = 2'b00;
    inj_data     = 1'b0;
    inj_valid    = 1'b0;
    done         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // reset_n gating keeps ack low while the async reset is held.
        if (req != 2'b00 && reset_n) begin
          ack[winner]  = 1'b1;
          shreg_d      = winner ? data1 : data0;
          owner_d      = winner;
          last_owner_d = winner;
          cnt_d        = '0;
          state_d      = S_SHIFT;
        end
      end
      S_SHIFT: begin
        inj_data  = shreg_q[WIDTH-1];
        inj_valid = 1'b1;
        shreg_d   = shreg_q << 1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CntWordLast) begin
          cnt_d   = '0;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CntFlushLast) begin
          done    = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter, shift register and ownership registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign owner = owner_q;

  shift_chain #(
    .DEPTH(DEPTH)
  ) u_chain (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  (inj_data),
    .in_valid (inj_valid),
    .out_data (ser_out),
    .out_valid(ser_valid)
  );

endmodule

// File: tb/tb_shift_sched.sv
// Self-checking bench for shift_sched. The reference model schedules each
// granted word as a block of future expected outputs using the timing rules
// (payload at A+1+DEPTH.., done at A+WIDTH+DEPTH, next grant after that).
module tb_shift_sched;

  localparam int W    = 8;
  localparam int D    = 3;
  localparam int RING = 64;

  logic         clk;
  logic         reset_n;
  logic [1:0]   req;
  logic [W-1:0] data0;
  logic [W-1:0] data1;
  logic [1:0]   ack;
  logic         ser_out;
  logic         ser_valid;
  logic         owner;
  logic         busy;
  logic         done;

  shift_sched #(
    .WIDTH(W),
    .DEPTH(D),
    .CNT_W(5)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .data0    (data0),
    .data1    (data1),
    .ack      (ack),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .owner    (owner),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int granted;

  // Model state: expected outputs per future cycle, plus arbitration memory.
  logic ev [RING];
  logic eb [RING];
  logic ed [RING];
  logic ebusy [RING];
  int   free_at;
  logic m_last;
  logic m_owner;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < RING; i++) begin
      ev[i] = 0; eb[i] = 0; ed[i] = 0; ebusy[i] = 0;
    end
    free_at = cyc;
    m_last  = 1'b1;
    m_owner = 1'b0;
  endtask

  // One clock cycle: predict, compare at the negedge, then advance.
  task automatic step();
    logic [1:0]   e_ack;
    logic [W-1:0] word;
    int           s;
    @(negedge clk);
    granted = -1;
    e_ack   = 2'b00;
    if (!reset_n) model_reset();
    else if (cyc >= free_at && req != 2'b00) begin
      if (req == 2'b01) granted = 0;
      else if (req == 2'b10) granted = 1;
      else granted = m_last ? 0 : 1;
      e_ack[granted] = 1'b1;
    end
    s = cyc % RING;
    chk("ack", {30'd0, ack}, {30'd0, e_ack});
    chk("ser_valid", {31'd0, ser_valid}, {31'd0, ev[s]});
    chk("ser_out", {31'd0, ser_out}, {31'd0, eb[s]});
    chk("done", {31'd0, done}, {31'd0, ed[s]});
    chk("busy", {31'd0, busy}, {31'd0, ebusy[s]});
    chk("owner", {31'd0, owner}, {31'd0, m_owner});
    ev[s] = 0; eb[s] = 0; ed[s] = 0; ebusy[s] = 0;
    if (granted >= 0) begin
      word = (granted == 1) ? data1 : data0;
      for (int k = 0; k < W; k++) begin
        ev[(cyc + 1 + D + k) % RING] = 1'b1;
        eb[(cyc + 1 + D + k) % RING] = word[W-1-k];
      end
      for (int k = 1; k <= W + D; k++) ebusy[(cyc + k) % RING] = 1'b1;
      ed[(cyc + W + D) % RING] = 1'b1;
      free_at = cyc + W + D + 1;
      m_last  = granted[0];
      m_owner = granted[0];
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Run n cycles; a served source drops its request unless keep is set.
  task automatic run(input int n, input bit keep);
    for (int i = 0; i < n; i++) begin
      step();
      if (granted >= 0 && !keep) req[granted] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = 2'b00;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    req     = 2'b00;
    data0   = '0;
    data1   = '0;
    cyc     = 0;
    model_reset();
    #1;
    do_reset();

    // Single word from source 0.
    data0 = 8'hA5; req = 2'b01;
    run(14, 1'b0);

    // Simultaneous requests from reset: source 0 first, then source 1.
    do_reset();
    data0 = 8'h0F; data1 = 8'hF0; req = 2'b11;
    run(26, 1'b0);

    // Both held high for four words: alternation 0,1,0,1.
    do_reset();
    data0 = 8'h3C; data1 = 8'h96; req = 2'b11;
    run(48, 1'b1);
    req = 2'b00;
    run(14, 1'b0);

    // Late request from source 1 during a source-0 transfer.
    do_reset();
    data0 = 8'h5A; req = 2'b01;
    run(5, 1'b0);
    data1 = 8'hE7; req[1] = 1'b1;
    run(22, 1'b0);

    // Reset in the middle of a word.
    do_reset();
    data0 = 8'hC3; req = 2'b01;
    run(7, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("rst_ser_valid", {31'd0, ser_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    req = 2'b01; data0 = 8'h81;
    run(2, 1'b0);
    reset_n = 1'b1;
    req = 2'b01;
    run(14, 1'b0);

    // Idle stability.
    do_reset();
    run(50, 1'b0);

    // Randomised traffic with one reset in the middle.
    for (int i = 0; i < 2000; i++) begin
      for (int s = 0; s < 2; s++) begin
        if (!req[s]) begin
          if ($urandom_range(3) == 0) begin
            req[s] = 1'b1;
            if (s == 0) data0 = W'($urandom); else data1 = W'($urandom);
          end
        end else if ($urandom_range(31) == 0) begin
          req[s] = 1'b0;
        end
      end
      if (i == 1000) reset_n = 1'b0;
      if (i == 1003) reset_n = 1'b1;
      step();
      if (granted >= 0) begin
        if ($urandom_range(1) == 0) req[granted] = 1'b0;
        else if (granted == 0) data0 = W'($urandom);
        else data1 = W'($urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_sched.md
Name: shift_sched

Overview:
- Two-requester scheduler that shares a single DEPTH-stage serial shift chain between two parallel-word sources.
- Arbitrates round-robin and captures the winning WIDTH-bit word. Serializes it MSB-first into the chain, then flushes the chain before granting again.
- Sits between parallel producers and a serial link. Owns sequencing, framing (ser_valid) and completion signalling of the shift datapath.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- DEPTH, 3, number of flop stages in the serial chain; legal range 1..16.
- CNT_W, 5, width of the bit/flush counter; must hold max(WIDTH, DEPTH)-1.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  2  request per source; held high until acked.
- data0  input  WIDTH  word from source 0; valid while req[0] high.
- data1  input  WIDTH  word from source 1; valid while req[1] high.
- ack  output  2  one-cycle grant/accept pulse; data sampled on this cycle.
- ser_out  output  1  serial data at chain tail.
- ser_valid  output  1  high when ser_out carries a payload bit.
- owner  output  1  index of the source whose word is in flight.
- busy  output  1  high when state is not IDLE.
- done  output  1  one-cycle pulse when the last bit of a word is on ser_out.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; ack=0, ser_out=0, ser_valid=0, owner=0, busy=0, done=0. Chain flops, shift register and counter cleared. last_owner=1, so source 0 wins the first tie.
- States are IDLE, SHIFT and FLUSH.
- IDLE:
  - if req != 0, select a winner. A single requester wins outright. If both request, the winner is the source != last_owner.
  - Same cycle: ack[winner]=1 (combinational from state/req/last_owner), shift register <= winner's data, owner <= winner, last_owner <= winner, cnt <= 0; next state SHIFT.
  - If req == 0, stay in IDLE and inject 0 with valid=0.
- SHIFT:
  - Each cycle inject shreg[WIDTH-1] with valid=1 into chain stage 0, shift shreg left by 1, cnt++.
  - After the cycle with cnt==WIDTH-1: cnt <= 0, next state FLUSH.
- FLUSH:
  - Inject 0 with valid=0; cnt++.
  - In the cycle with cnt==DEPTH-1: done=1, next state IDLE.
- Chain:
  - 2-bit-wide (data, valid) registered pipeline of DEPTH stages. ser_out and ser_valid are the tail stage.
  - A bit injected in cycle t is visible on ser_out in cycle t+DEPTH.
- Timing, with ack in cycle A:
  - payload bits appear on cycles A+1+DEPTH .. A+WIDTH+DEPTH.
  - done coincides with the last payload bit (cycle A+WIDTH+DEPTH).
  - busy is high on cycles A+1 .. A+WIDTH+DEPTH.
  - earliest next ack is cycle A+WIDTH+DEPTH+1.
  - throughput is one word per WIDTH+DEPTH+1 cycles.
- No request is acked while busy. A req rising during SHIFT/FLUSH waits.
- A requester dropping req before ack is simply not served; this is not an error.
- A requester that keeps req high after its ack is treated as a new request. Round-robin still alternates when both are asserted.
- reset_n asserted mid-word: the word is lost, no done pulse, and ser_valid drops immediately (asynchronous clear).
- ack is never asserted while reset_n is low.

Decomposition:
- Shared include (shift_defs):
  - state encodings S_IDLE=2'd0, S_SHIFT=2'd1, S_FLUSH=2'd2;
  - parameter range limits.
- One sub-module, shift_chain: parameterised DEPTH x 2-bit flop pipeline with async active-low clear. It is the serial datapath reused from the existing flop-chain style.
- Arbiter, FSM, counter and shift register stay in shift_sched.

Test Plan (WIDTH=8, DEPTH=3):
- Single word: req[0]=1, data0=8'hA5 at cycle 0 -> ack=2'b01 at cycle 0. ser_valid high on cycles 4..11. ser_out=1,0,1,0,0,1,0,1. done on cycle 11. busy on cycles 1..11.
- Simultaneous requests: req=2'b11, data0=8'h0F, data1=8'hF0 from reset -> source 0 acked at cycle 0. Source 1 acked at cycle 12 with owner=1. Its bits 1,1,1,1,0,0,0,0 appear on cycles 16..23.
- Round-robin fairness: hold req=2'b11 for 4 words -> ack order 0,1,0,1. Ack cycles are 0, 12, 24, 36.
- Late request: req[1] raised at cycle 5 during source-0 transfer -> no ack until cycle 12. ser_valid never high on cycles 0..3 or 12..15.
- Reset mid-operation: reset_n low at cycle 7 of a transfer -> ser_valid, busy and done at 0 immediately, no done pulse. After release with req[0]=1, ack on the first active cycle and a full 8-bit word is re-sent.
- Idle stability: req=0 for 50 cycles after reset -> ack, ser_valid, busy and done remain 0, and ser_out stays 0.
